// File: rtl/seq_serial_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_serial_tx_if                                               |
// | Purpose : start/ready handshake plus serial output bundle for the        |
// |           serial pattern transmitter.                                    |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface seq_serial_tx_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] seq;
  logic             ready;
  logic             a;
  logic             busy;
  logic             done;

  modport master (output start, seq, input ready, a, busy, done);
  modport slave  (input start, seq, output ready, a, busy, done);
endinterface
`default_nettype wire

// File: rtl/seq_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seq_serial_tx                                                  |
// | Purpose : shifts a parallel word out MSB first on a, one bit per clk,    |
// |           with optional idle gap. Define SEQ_TX_PARITY_EN to append an   |
// |           even-parity bit after the LSB.                                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seq_serial_tx #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  seq_serial_tx_if.slave bus
);

`ifdef SEQ_TX_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam int              GW   = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0]   LAST = CW'(FLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [FLEN-1:0] sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            a_q, a_d;

  logic [FLEN-1:0] w_frame;
  logic            w_last;
  logic            w_ready;
  logic            w_accept;

`ifdef SEQ_TX_PARITY_EN
  assign w_frame = {bus.seq, ^bus.seq};
`else
  assign w_frame = bus.seq;
`endif

  assign w_last   = (state_q == ST_SHIFT) && (cnt_q == LAST);
  assign w_ready  = (state_q == ST_IDLE) || (w_last && (GAP == 0));
  assign w_accept = bus.start && w_ready;

  assign bus.ready = w_ready;
  assign bus.a     = a_q;
  assign bus.busy  = (state_q != ST_IDLE);
  assign bus.done  = w_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      a_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      a_q     <= a_d;
    end
  end

  // sh_q holds only the bits still to come; a_q already carries the current one.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    a_d     = a_q;

    case (state_q)
      ST_SHIFT: begin
        if (!w_last) begin
          a_d   = sh_q[FLEN-1];
          sh_d  = sh_q << 1;
          cnt_d = cnt_q + CW'(1);
        end else begin
          a_d = 1'b0;
          if (GAP > 0) begin
            state_d = ST_GAP;
            gcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        a_d     = 1'b0;
      end
    endcase

    // Accept overrides both IDLE and the final SHIFT cycle (back-to-back reload).
    if (w_accept) begin
      state_d = ST_SHIFT;
      a_d     = w_frame[FLEN-1];
      sh_d    = w_frame << 1;
      cnt_d   = '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_serial_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seq_serial_tx                                               |
// | Purpose : self-checking bench for seq_serial_tx (GAP=0 and GAP=2).       |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_seq_serial_tx;
  localparam int WIDTH = 4;
  localparam int MAXC  = 1024;
`ifdef SEQ_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  // Expected outputs per DUT per absolute cycle, filled when a frame is accepted.
  bit exp_a  [2][MAXC];
  bit exp_b  [2][MAXC];
  bit exp_dn [2][MAXC];

  seq_serial_tx_if #(.WIDTH(WIDTH)) if0 ();
  seq_serial_tx_if #(.WIDTH(WIDTH)) if1 ();

  seq_serial_tx #(.WIDTH(WIDTH), .GAP(0)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  seq_serial_tx #(.WIDTH(WIDTH), .GAP(2)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1.slave));

  always #5 clk = ~clk;

  logic [1:0]       st_v, a_v, b_v, dn_v, rd_v;
  logic [WIDTH-1:0] sq_v [2];
  assign st_v   = {if1.start, if0.start};
  assign a_v    = {if1.a,     if0.a};
  assign b_v    = {if1.busy,  if0.busy};
  assign dn_v   = {if1.done,  if0.done};
  assign rd_v   = {if1.ready, if0.ready};
  assign sq_v[0] = if0.seq;
  assign sq_v[1] = if1.seq;

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic bit m_ready(input int d, input int c);
    return !exp_b[d][c] || (gap_of(d) == 0 && exp_dn[d][c]);
  endfunction

  function automatic bit fbit(input logic [WIDTH-1:0] s, input int k);
    return (k < WIDTH) ? s[WIDTH-1-k] : ^s;
  endfunction

  task automatic chk(input string nm, input logic act, input logic expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %b, want %b (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAXC; i++) begin
        if (i >= cyc) begin
          for (int d = 0; d < 2; d++) begin
            exp_a[d][i]  <= 1'b0;
            exp_b[d][i]  <= 1'b0;
            exp_dn[d][i] <= 1'b0;
          end
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (st_v[d] && m_ready(d, cyc)) begin
          for (int k = 0; k < FL; k++) begin
            exp_a[d][cyc+1+k]  <= fbit(sq_v[d], k);
            exp_b[d][cyc+1+k]  <= 1'b1;
            exp_dn[d][cyc+1+k] <= (k == FL - 1);
          end
          for (int g = 0; g < gap_of(d); g++) begin
            exp_a[d][cyc+1+FL+g]  <= 1'b0;
            exp_b[d][cyc+1+FL+g]  <= 1'b1;
            exp_dn[d][cyc+1+FL+g] <= 1'b0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("u%0d.a", d),     a_v[d],  exp_a[d][cyc]);
      chk($sformatf("u%0d.busy", d),  b_v[d],  exp_b[d][cyc]);
      chk($sformatf("u%0d.done", d),  dn_v[d], exp_dn[d][cyc]);
      chk($sformatf("u%0d.ready", d), rd_v[d], m_ready(d, cyc));
    end
  end

  task automatic send(input int d, input logic [WIDTH-1:0] s);
    @(negedge clk);
    if (d == 0) begin if0.start = 1'b1; if0.seq = s; end
    else        begin if1.start = 1'b1; if1.seq = s; end
    @(negedge clk);
    if (d == 0) if0.start = 1'b0;
    else        if1.start = 1'b0;
  endtask

  // Literal check of n consecutive cycles starting at the current negedge; MSB of ab/db first.
  task automatic lit(input int d, input string nm, input int n,
                     input logic [15:0] ab, input logic [15:0] db);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("%s.a[%0d]", nm, k),    a_v[d],  ab[n-1-k]);
      chk($sformatf("%s.done[%0d]", nm, k), dn_v[d], db[n-1-k]);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    if0.start = 1'b0; if0.seq = '0;
    if1.start = 1'b0; if1.seq = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst.ready", if0.ready, 1'b1);
    chk("rst.busy",  if0.busy,  1'b0);
    chk("rst.a",     if0.a,     1'b0);
    chk("rst.done",  if0.done,  1'b0);

    // single frame
    send(0, 4'b1011);
`ifndef SEQ_TX_PARITY_EN
    lit(0, "t1", 4, 16'b1011, 16'b0001);
`else
    lit(0, "t1", 5, 16'b10111, 16'b00001);
`endif
    repeat (2) @(negedge clk);

    // start held high: back-to-back frames, seq resampled at second accept
    if0.start = 1'b1; if0.seq = 4'b1100;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) if0.seq = 4'b0110;
      if (k == 5) if0.start = 1'b0;
`ifndef SEQ_TX_PARITY_EN
      chk($sformatf("t2.a[%0d]", k),    if0.a,    8'b11000110 >> (8 - k) & 1'b1);
      chk($sformatf("t2.done[%0d]", k), if0.done, (k == 4) || (k == 8));
`endif
    end
    repeat (2) @(negedge clk);

    // GAP=2 instance: gap cycles, start during gap ignored
    send(1, 4'b1111);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 5) if1.start = 1'b1;
      if (k == 6) if1.start = 1'b0;
`ifndef SEQ_TX_PARITY_EN
      if (k <= 6) begin
        chk($sformatf("t3.ready[%0d]", k), if1.ready, 1'b0);
        chk($sformatf("t3.a[%0d]", k),     if1.a,     k <= 4);
      end else begin
        chk("t3.ready_after", if1.ready, 1'b1);
        chk("t3.busy_after",  if1.busy,  1'b0);
      end
`endif
    end
    repeat (3) @(negedge clk);

    // async reset mid-frame, with start asserted during reset
    send(0, 4'b1010);
    @(negedge clk);
    @(negedge clk);
    chk("t4.a_bit2", if0.a, 1'b1);
    #2;
    reset_n   = 1'b0;
    if0.start = 1'b1; if0.seq = 4'b1111;
    #1;
    chk("t4.rst_a",     if0.a,     1'b0);
    chk("t4.rst_busy",  if0.busy,  1'b0);
    chk("t4.rst_done",  if0.done,  1'b0);
    chk("t4.rst_ready", if0.ready, 1'b1);
    repeat (2) @(negedge clk);
    if0.start = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    chk("t4.idle_busy", if0.busy, 1'b0);
    chk("t4.idle_a",    if0.a,    1'b0);
    send(0, 4'b1010);
`ifndef SEQ_TX_PARITY_EN
    lit(0, "t4f", 4, 16'b1010, 16'b0001);
`else
    lit(0, "t4f", 5, 16'b10100, 16'b00001);
`endif
    repeat (2) @(negedge clk);

    // start mid-frame is ignored
    send(0, 4'b1011);
    @(negedge clk);
    if0.start = 1'b1; if0.seq = 4'b0001;
    chk("t5.a_bit1", if0.a, 1'b0);
    @(negedge clk);
    if0.start = 1'b0;
    chk("t5.a_bit2", if0.a, 1'b1);
    @(negedge clk);
    chk("t5.a_bit3", if0.a, 1'b1);
`ifndef SEQ_TX_PARITY_EN
    chk("t5.done", if0.done, 1'b1);
    @(negedge clk);
    chk("t5.busy_end", if0.busy, 1'b0);
`endif
    repeat (2) @(negedge clk);

`ifdef SEQ_TX_PARITY_EN
    send(0, 4'b0111);
    lit(0, "t6", 5, 16'b01111, 16'b00001);
    repeat (2) @(negedge clk);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
